// File: rtl/rgb2hsv_seq_ctrl.sv
// rgb2hsv_seq_ctrl
//   Sequencer for the RGB->HSV conversion path. A single restoring divider
//   is shared between the saturation and hue-fraction divisions. Each
//   division produces one quotient bit per cycle, so latency is fixed.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     in_valid/in_ready   pixel handshake; in_ready is high only when idle
//     r, g, b             unsigned input channels, CW bits each
//     out_valid/out_ready result handshake; h/s/v hold until accepted
//     h                   hue, 0 .. 6*H_SECT
//     s                   saturation, 0 .. S_SCALE
//     v                   value = max(r,g,b)
//     busy                sequencer is not idle
module rgb2hsv_seq_ctrl #(
    parameter int CW      = 10,
    parameter int HW      = 12,
    parameter int S_SCALE = 1023,
    parameter int H_SECT  = 682
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [HW-1:0] h,
    output logic [CW-1:0] s,
    output logic [CW-1:0] v,
    output logic          busy
);

    localparam int CNTW = $clog2(CW);
    localparam logic [CNTW-1:0] LAST = CNTW'(CW - 1);
    localparam logic [2*CW-1:0] SS   = (2*CW)'(S_SCALE);
    localparam logic [2*CW-1:0] HS   = (2*CW)'(H_SECT);
    localparam logic [HW-1:0]   H2   = HW'(2 * H_SECT);
    localparam logic [HW-1:0]   H4   = HW'(4 * H_SECT);
    localparam logic [HW-1:0]   H6   = HW'(6 * H_SECT);

    typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;
    typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

    state_t        st;
    sector_t       sec;
    logic [CW-1:0] rr, gg, bb;
    logic [CW-1:0] mx, dl, an;
    logic          neg;
    logic [CW-1:0] rem, lo, dvs, quo;
    logic [CW-1:0] sq, frac;
    logic [CNTW-1:0] cnt;

    // Pixel analysis from the captured channels (used during PREP).
    sector_t       sec_c;
    logic [CW-1:0] mx_c, mn_c, dl_c, an_c;
    logic          neg_c;
    logic [2*CW-1:0] prod_s, prod_h;

    always_comb begin
        sec_c = SEC_R;
        mx_c  = rr;
        neg_c = 1'b0;
        an_c  = '0;
        if (rr >= gg && rr >= bb) begin
            sec_c = SEC_R;
            mx_c  = rr;
            neg_c = gg < bb;
            an_c  = neg_c ? bb - gg : gg - bb;
        end else if (gg >= bb) begin
            sec_c = SEC_G;
            mx_c  = gg;
            neg_c = bb < rr;
            an_c  = neg_c ? rr - bb : bb - rr;
        end else begin
            sec_c = SEC_B;
            mx_c  = bb;
            neg_c = rr < gg;
            an_c  = neg_c ? gg - rr : rr - gg;
        end
        mn_c = rr;
        if (gg < mn_c) mn_c = gg;
        if (bb < mn_c) mn_c = bb;
        dl_c   = mx_c - mn_c;
        prod_s = {{CW{1'b0}}, dl_c} * SS;
        prod_h = {{CW{1'b0}}, an} * HS;
    end

    // One restoring-divider step. The upper dividend half is always below
    // the divisor, so the partial remainder fits in CW bits.
    logic [CW:0]   shifted;
    logic          ge;
    logic [CW-1:0] rem_n, quo_n;

    always_comb begin
        shifted = {rem, lo[CW-1]};
        ge      = shifted >= {1'b0, dvs};
        rem_n   = ge ? shifted[CW-1:0] - dvs : shifted[CW-1:0];
        quo_n   = {quo[CW-2:0], ge};
    end

    // Hue assembly from the sector base and the signed fraction.
    logic [HW-1:0] base, h_c;

    always_comb begin
        case (sec)
            SEC_G:   base = H2;
            SEC_B:   base = H4;
            default: base = neg ? H6 : '0;
        endcase
        h_c = neg ? base - HW'(frac) : base + HW'(frac);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            sec       <= SEC_R;
            rr        <= '0;
            gg        <= '0;
            bb        <= '0;
            mx        <= '0;
            dl        <= '0;
            an        <= '0;
            neg       <= 1'b0;
            rem       <= '0;
            lo        <= '0;
            dvs       <= '0;
            quo       <= '0;
            sq        <= '0;
            frac      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            h         <= '0;
            s         <= '0;
            v         <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        rr <= r;
                        gg <= g;
                        bb <= b;
                        st <= PREP;
                    end
                end
                PREP: begin
                    sec <= sec_c;
                    mx  <= mx_c;
                    dl  <= dl_c;
                    an  <= an_c;
                    neg <= neg_c;
                    rem <= prod_s[2*CW-1:CW];
                    lo  <= prod_s[CW-1:0];
                    dvs <= mx_c;
                    quo <= '0;
                    cnt <= '0;
                    st  <= DIV_S;
                end
                DIV_S: begin
                    rem <= rem_n;
                    lo  <= {lo[CW-2:0], 1'b0};
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Zero divisor still runs the full schedule; mask here.
                        sq  <= (dvs == '0) ? '0 : quo_n;
                        rem <= prod_h[2*CW-1:CW];
                        lo  <= prod_h[CW-1:0];
                        dvs <= dl;
                        quo <= '0;
                        cnt <= '0;
                        st  <= DIV_H;
                    end
                end
                DIV_H: begin
                    rem <= rem_n;
                    lo  <= {lo[CW-2:0], 1'b0};
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        frac <= (dvs == '0) ? '0 : quo_n;
                        cnt  <= '0;
                        st   <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle assembles the result; afterwards wait
                    // for the downstream handshake.
                    if (!out_valid) begin
                        h         <= (dl == '0) ? '0 : h_c;
                        s         <= sq;
                        v         <= mx;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign in_ready = (st == IDLE);
    assign busy     = (st != IDLE);

endmodule

// File: tb/tb_rgb2hsv_seq_ctrl.sv
// Directed bench for rgb2hsv_seq_ctrl: hand-computed H/S/V per pixel,
// latency, output hold under back-pressure and mid-operation reset.
module tb_rgb2hsv_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] r = '0, g = '0, b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [11:0] h;
    logic [9:0] s, v;
    logic       busy;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    rgb2hsv_seq_ctrl #(.CW(10), .HW(12), .S_SCALE(1023), .H_SECT(682)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .h(h), .s(s), .v(v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // Offer a pixel, wait for the result (bounded) and check latency.
    task automatic start_pixel(input int unsigned pr, input int unsigned pg, input int unsigned pb,
                               input string tag);
        int unsigned lat;
        @(negedge clk);
        r = 10'(pr); g = 10'(pg); b = 10'(pb);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 100);
        check({tag, "_lat"}, lat, 22);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ovclr"}, out_valid, 0);
        check({tag, "_irdy"}, in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pixel(input int unsigned pr, input int unsigned pg, input int unsigned pb,
                         input int unsigned eh, input int unsigned es, input int unsigned ev,
                         input string tag);
        start_pixel(pr, pg, pb, tag);
        check({tag, "_h"}, h, eh);
        check({tag, "_s"}, s, es);
        check({tag, "_v"}, v, ev);
        handshake(tag);
    endtask

    initial begin
        #12;
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hsv", {h, s, v}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_irdy", in_ready, 1);

        // h/s/v: s = delta*1023/max, frac = |num|*682/delta
        pixel(1023, 0, 0, 0, 1023, 1023, "T1_red");
        pixel(0, 0, 0, 0, 0, 0, "T2_black");
        pixel(512, 512, 512, 0, 0, 512, "T2_gray");
        pixel(0, 1023, 0, 1364, 1023, 1023, "T3_green");
        pixel(0, 0, 1023, 2728, 1023, 1023, "T3_blue");
        // num=-512, frac=349184/1023=341, h=4092-341
        pixel(1023, 0, 512, 3751, 1023, 1023, "T3_rneg");
        // delta=700, max=800: s=716100/800=895, frac=682
        pixel(800, 800, 100, 682, 895, 800, "T4_tie");
        // g sector, num=+100, delta=200: frac=341; s=204600/300=682
        pixel(100, 300, 200, 1705, 682, 300, "gpos");
        pixel(200, 100, 300, 3069, 682, 300, "bpos");
        pixel(100, 200, 300, 2387, 682, 300, "bneg");

        // T5: back-pressure with a competing pixel offered
        start_pixel(0, 0, 1023, "T5");
        @(negedge clk);
        r = 10'd5; g = 10'd6; b = 10'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("T5_hold_ov", out_valid, 1);
            check("T5_hold_irdy", in_ready, 0);
            check("T5_hold_h", h, 2728);
            check("T5_hold_sv", {s, v}, {10'd1023, 10'd1023});
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("T5");
        check("T5_keep_h", h, 2728);
        check("T5_idle", busy, 0);

        // T6: reset during DIV_S
        @(negedge clk);
        r = 10'd0; g = 10'd1023; b = 10'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("T6_ov", out_valid, 0);
        check("T6_busy", busy, 0);
        check("T6_hsv", {h, s, v}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pixel(0, 1023, 0, 1364, 1023, 1023, "T6_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
